// File: rtl/timer_testbench_if.sv
// APB register bus for the timer peripheral.
interface timer_testbench_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/timer_testbench.sv
// 8-bit programmable up/down timer with APB register slave, sticky OVF/UDF
// status flags and level interrupt outputs.
module timer_testbench #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              pclk,
    input  logic              preset,
    timer_testbench_if.slave  bus,
    output logic              tmr_ovf,
    output logic              tmr_udf
);

    logic [DATA_W-1:0] r_tdr;
    logic [DATA_W-1:0] r_tcr;
    logic [1:0]        r_tsr;
    logic [DATA_W-1:0] r_tcnt;
    logic [3:0]        r_div;

    logic              w_access;
    logic              w_wr;
    logic              w_addr_ok;
    logic [3:0]        w_mask;
    logic              w_tick;
    logic              w_ovf_set;
    logic              w_udf_set;
    logic [DATA_W-1:0] w_tcnt_d;
    logic [1:0]        w_tsr_d;
    logic [DATA_W-1:0] w_rdata;

    assign w_access  = bus.psel & bus.penable;
    assign w_wr      = w_access & bus.pwrite;
    assign w_addr_ok = (bus.paddr < ADDR_W'(4));

    // Prescaler tick: low (cks+1) divider bits all ones.
    always_comb begin
        w_mask = 4'((5'd2 << r_tcr[1:0]) - 5'd1);
        w_tick = ((r_div & w_mask) == w_mask);
    end

    // Counter next state and hardware flag sets; load overrides counting.
    always_comb begin
        w_tcnt_d  = r_tcnt;
        w_ovf_set = 1'b0;
        w_udf_set = 1'b0;
        if (r_tcr[7]) begin
            w_tcnt_d = r_tdr;
        end else if (r_tcr[4] && w_tick) begin
            if (r_tcr[5]) begin
                w_tcnt_d  = r_tcnt - DATA_W'(1);
                w_udf_set = (r_tcnt == '0);
            end else begin
                w_tcnt_d  = r_tcnt + DATA_W'(1);
                w_ovf_set = (r_tcnt == '1);
            end
        end
    end

    // Status next state: write-0-to-clear, then hardware set wins.
    always_comb begin
        w_tsr_d = r_tsr;
        if (w_wr && bus.paddr == ADDR_W'(2)) begin
            w_tsr_d = r_tsr & bus.pwdata[1:0];
        end
        w_tsr_d = w_tsr_d | {w_udf_set, w_ovf_set};
    end

    // Register read mux; out-of-range addresses read zero.
    always_comb begin
        w_rdata = '0;
        case (bus.paddr)
            ADDR_W'(0): w_rdata = r_tdr;
            ADDR_W'(1): w_rdata = r_tcr;
            ADDR_W'(2): w_rdata = {{(DATA_W-2){1'b0}}, r_tsr};
            ADDR_W'(3): w_rdata = r_tcnt;
            default:    w_rdata = '0;
        endcase
    end

    // Register state; TCR bits 6, 3 and 2 are never stored.
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_tdr  <= '0;
            r_tcr  <= '0;
            r_tsr  <= '0;
            r_tcnt <= '0;
            r_div  <= '0;
        end else begin
            r_div  <= r_div + 4'd1;
            r_tcnt <= w_tcnt_d;
            r_tsr  <= w_tsr_d;
            if (w_wr && bus.paddr == ADDR_W'(0)) begin
                r_tdr <= bus.pwdata;
            end
            if (w_wr && bus.paddr == ADDR_W'(1)) begin
                r_tcr <= bus.pwdata & DATA_W'(8'hB3);
            end
        end
    end

    assign bus.prdata  = (bus.psel && !bus.pwrite) ? w_rdata : '0;
    assign bus.pready  = 1'b1;
    // TCNT is read-only, so a write there is an error as well.
    assign bus.pslverr = w_access & (~w_addr_ok | (bus.pwrite & (bus.paddr == ADDR_W'(3))));
    assign tmr_ovf     = r_tsr[0];
    assign tmr_udf     = r_tsr[1];

endmodule

// File: tb/tb_timer_testbench.sv
// Self-checking bench for timer_testbench: vector table, directed corner
// sequences and randomized APB traffic against a behavioural model.
module tb_timer_testbench;

    logic pclk = 1'b0;
    logic preset;
    logic tmr_ovf;
    logic tmr_udf;
    int   checks = 0;
    int   errors = 0;

    timer_testbench_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    timer_testbench #(.ADDR_W(8), .DATA_W(8)) dut (
        .pclk    (pclk),
        .preset  (preset),
        .bus     (bus.slave),
        .tmr_ovf (tmr_ovf),
        .tmr_udf (tmr_udf)
    );

    always #5 pclk = ~pclk;

    // Behavioural model state.
    logic [7:0] m_tdr  = 8'h00;
    logic [7:0] m_tcr  = 8'h00;
    logic [1:0] m_tsr  = 2'b00;
    logic [7:0] m_tcnt = 8'h00;
    int         m_cyc  = 0;

    // Model: prescaler phase is the number of edges since reset modulo the divisor.
    always @(posedge pclk) begin : model
        int         d;
        int         n;
        logic [1:0] set;
        logic [1:0] tsr;
        if (preset) begin
            m_tdr  <= 8'h00;
            m_tcr  <= 8'h00;
            m_tsr  <= 2'b00;
            m_tcnt <= 8'h00;
            m_cyc  <= 0;
        end else begin
            d   = 2 << m_tcr[1:0];
            n   = m_tcnt;
            set = 2'b00;
            if (m_tcr[7]) begin
                n = m_tdr;
            end else if (m_tcr[4] && (m_cyc % d == d - 1)) begin
                if (m_tcr[5]) begin
                    n = m_tcnt - 1;
                    if (n < 0) begin
                        n = 255;
                        set[1] = 1'b1;
                    end
                end else begin
                    n = m_tcnt + 1;
                    if (n > 255) begin
                        n = 0;
                        set[0] = 1'b1;
                    end
                end
            end
            tsr = m_tsr;
            if (bus.psel && bus.penable && bus.pwrite) begin
                case (bus.paddr)
                    8'h00: m_tdr <= bus.pwdata;
                    8'h01: m_tcr <= {bus.pwdata[7], 1'b0, bus.pwdata[5:4], 2'b00, bus.pwdata[1:0]};
                    8'h02: tsr = tsr & bus.pwdata[1:0];
                    default: ;
                endcase
            end
            m_tsr  <= tsr | set;
            m_tcnt <= n[7:0];
            m_cyc  <= m_cyc + 1;
        end
    end

    function automatic logic [7:0] m_read(input logic [7:0] a);
        case (a)
            8'h00:   return m_tdr;
            8'h01:   return m_tcr;
            8'h02:   return {6'b0, m_tsr};
            8'h03:   return m_tcnt;
            default: return 8'h00;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    // One APB transfer, checked against the model during the access phase.
    task automatic apb(input logic wr, input logic [7:0] a, input logic [7:0] d,
                       output logic [7:0] rd, output logic err);
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = wr;
        bus.paddr   = a;
        bus.pwdata  = d;
        @(posedge pclk);
        #1;
        bus.penable = 1'b1;
        #1;
        rd  = bus.prdata;
        err = bus.pslverr;
        check($sformatf("pslverr a=%0h wr=%0b", a, wr), {31'b0, err},
              {31'b0, (a > 8'h03) || (wr && a == 8'h03)});
        if (!wr) check($sformatf("prdata a=%0h", a), {24'b0, rd}, {24'b0, m_read(a)});
        check("pready", {31'b0, bus.pready}, 32'd1);
        check("tmr_ovf", {31'b0, tmr_ovf}, {31'b0, m_tsr[0]});
        check("tmr_udf", {31'b0, tmr_udf}, {31'b0, m_tsr[1]});
        @(posedge pclk);
        #1;
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
    endtask

    task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
        logic [7:0] rd;
        logic       err;
        apb(1'b1, a, d, rd, err);
    endtask

    task automatic rd_reg(input logic [7:0] a, output logic [7:0] rd);
        logic err;
        apb(1'b0, a, 8'h00, rd, err);
    endtask

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rd;
        logic       exp_err;
    } vec_t;

    vec_t tbl [15];

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] rd;
        logic       err;
        int         waited;

        tbl = '{
            '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0},
            '{1'b0, 8'h01, 8'h00, 8'h00, 1'b0},
            '{1'b0, 8'h02, 8'h00, 8'h00, 1'b0},
            '{1'b0, 8'h03, 8'h00, 8'h00, 1'b0},
            '{1'b0, 8'h10, 8'h00, 8'h00, 1'b1},
            '{1'b0, 8'h04, 8'h00, 8'h00, 1'b1},
            '{1'b1, 8'h00, 8'h5A, 8'h00, 1'b0},
            '{1'b0, 8'h00, 8'h00, 8'h5A, 1'b0},
            '{1'b1, 8'h01, 8'hFF, 8'h00, 1'b0},
            '{1'b0, 8'h01, 8'h00, 8'hB3, 1'b0},
            '{1'b0, 8'h03, 8'h00, 8'h5A, 1'b0},
            '{1'b1, 8'h03, 8'h77, 8'h00, 1'b1},
            '{1'b0, 8'h03, 8'h00, 8'h5A, 1'b0},
            '{1'b1, 8'h01, 8'h00, 8'h00, 1'b0},
            '{1'b0, 8'h01, 8'h00, 8'h00, 1'b0}
        };

        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
        bus.paddr   = 8'h00;
        bus.pwdata  = 8'h00;
        preset      = 1'b1;
        idle(3);
        preset = 1'b0;
        check("reset tmr_ovf", {31'b0, tmr_ovf}, 32'd0);
        check("reset tmr_udf", {31'b0, tmr_udf}, 32'd0);
        check("reset prdata", {24'b0, bus.prdata}, 32'd0);
        check("reset pslverr", {31'b0, bus.pslverr}, 32'd0);

        for (int i = 0; i < 15; i++) begin
            apb(tbl[i].wr, tbl[i].addr, tbl[i].wdata, rd, err);
            check($sformatf("vec%0d err", i), {31'b0, err}, {31'b0, tbl[i].exp_err});
            if (!tbl[i].wr) check($sformatf("vec%0d rd", i), {24'b0, rd}, {24'b0, tbl[i].exp_rd});
        end

        // Up count /16 from 0x35: overflow after ~3248 pclk.
        wr_reg(8'h00, 8'h35);
        wr_reg(8'h01, 8'h80);
        wr_reg(8'h01, 8'h13);
        idle(640);
        rd_reg(8'h02, rd);
        check("up16 tsr early", {24'b0, rd}, 32'h00);
        idle(4096);
        rd_reg(8'h02, rd);
        check("up16 tsr ovf", {24'b0, rd}, 32'h01);
        check("up16 tmr_ovf", {31'b0, tmr_ovf}, 32'd1);
        wr_reg(8'h02, 8'h00);
        rd_reg(8'h02, rd);
        check("ovf clear tsr", {24'b0, rd}, 32'h00);
        check("ovf clear tmr_ovf", {31'b0, tmr_ovf}, 32'd0);

        // Down count /2 from 0x79: underflow after ~244 pclk.
        wr_reg(8'h00, 8'h79);
        wr_reg(8'h01, 8'h80);
        wr_reg(8'h01, 8'h30);
        idle(512);
        rd_reg(8'h02, rd);
        check("down2 tsr udf", {24'b0, rd}, 32'h02);
        check("down2 tmr_udf", {31'b0, tmr_udf}, 32'd1);
        rd_reg(8'h03, rd);

        // 0xFE up with cks=00: wrap to 0x00 within a few pclk.
        wr_reg(8'h02, 8'h00);
        wr_reg(8'h00, 8'hFE);
        wr_reg(8'h01, 8'h80);
        rd_reg(8'h03, rd);
        check("fe loaded", {24'b0, rd}, 32'hFE);
        wr_reg(8'h01, 8'h10);
        waited = 0;
        while (!tmr_ovf && waited < 16) begin
            idle(1);
            waited++;
        end
        check("fe ovf wait", {31'b0, tmr_ovf}, 32'd1);
        rd_reg(8'h03, rd);

        // Writing ones to TSR leaves flags untouched.
        wr_reg(8'h02, 8'h03);
        rd_reg(8'h02, rd);
        check("w1 no effect", {24'b0, rd}, 32'h01);

        apb(1'b0, 8'h10, 8'h00, rd, err);
        check("oob err", {31'b0, err}, 32'd1);
        check("oob rd", {24'b0, rd}, 32'h00);

        // load=1 with en=1 holds TCNT at TDR and sets no flags.
        wr_reg(8'h01, 8'h90);
        wr_reg(8'h02, 8'h00);
        idle(100);
        rd_reg(8'h03, rd);
        check("load hold tcnt", {24'b0, rd}, 32'hFE);
        rd_reg(8'h02, rd);
        check("load hold tsr", {24'b0, rd}, 32'h00);

        // Reset in the middle of counting.
        wr_reg(8'h00, 8'hFC);
        wr_reg(8'h01, 8'h10);
        idle(20);
        preset = 1'b1;
        idle(1);
        preset = 1'b0;
        check("midreset tmr_ovf", {31'b0, tmr_ovf}, 32'd0);
        for (int a = 0; a < 4; a++) begin
            rd_reg(8'(a), rd);
            check($sformatf("midreset rd%0d", a), {24'b0, rd}, 32'h00);
        end

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic [7:0] a;
            logic [7:0] d;
            logic       w;
            if ($urandom_range(0, 99) == 0) begin
                preset = 1'b1;
                idle(1);
                preset = 1'b0;
            end
            a = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(4, 255)) : 8'($urandom_range(0, 3));
            w = 1'($urandom_range(0, 1));
            d = 8'($urandom);
            if (a == 8'h01 && $urandom_range(0, 7) != 0) d[7] = 1'b0;
            if (a == 8'h00 && $urandom_range(0, 1) == 0) d = ($urandom_range(0, 1) == 0) ? 8'hFD : 8'h02;
            apb(w, a, d, rd, err);
            idle($urandom_range(0, 30));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
